// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronizers, ps2_clk glitch filter, 11-bit
// frame deframer with parity/framing/timeout checks, and a first-word-fall-
// through scancode FIFO with a valid/ready pop interface.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- input synchronizers (bit 0 = ps2_clk, bit 1 = ps2_data)
  logic [1:0] w_pin;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  assign w_pin = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      // Two-flop synchronizer, preset to the idle-high bus level.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_sync1[gi] <= 1'b1;
          r_sync2[gi] <= 1'b1;
        end else begin
          r_sync1[gi] <= w_pin[gi];
          r_sync2[gi] <= r_sync1[gi];
        end
      end
    end
  endgenerate

  logic w_clk_s;
  logic w_dat_s;
  assign w_clk_s = r_sync2[0];
  assign w_dat_s = r_sync2[1];

  // ---------------- ps2_clk filter and falling-edge strobe
  logic       r_filt_clk;
  logic [7:0] r_filt_cnt;
  logic       r_fall;

  // Accept a new clock level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_clk_s != r_filt_clk) begin
        if (r_filt_cnt == FILT_LAST) begin
          r_filt_clk <= w_clk_s;
          r_filt_cnt <= '0;
          r_fall     <= ~w_clk_s;
        end else begin
          r_filt_cnt <= r_filt_cnt + 8'd1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  // ---------------- deframer FSM
  state_t          r_state, w_state_next;
  logic [2:0]      r_bitcnt, w_bitcnt_next;
  logic [7:0]      r_shreg, w_shreg_next;
  logic            r_par, w_par_next;
  logic [TW-1:0]   r_tmo, w_tmo_next;
  logic            r_push, w_push_next;
  logic            r_perr, w_perr_next;
  logic            r_ferr, w_ferr_next;

  // State and datapath registers of the deframer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_par    <= 1'b0;
      r_tmo    <= '0;
      r_push   <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_bitcnt <= w_bitcnt_next;
      r_shreg  <= w_shreg_next;
      r_par    <= w_par_next;
      r_tmo    <= w_tmo_next;
      r_push   <= w_push_next;
      r_perr   <= w_perr_next;
      r_ferr   <= w_ferr_next;
    end
  end

  // Next-state logic: advance one bit per filtered fall; abort on inactivity.
  always_comb begin
    w_state_next  = r_state;
    w_bitcnt_next = r_bitcnt;
    w_shreg_next  = r_shreg;
    w_par_next    = r_par;
    w_tmo_next    = '0;
    w_push_next   = 1'b0;
    w_perr_next   = 1'b0;
    w_ferr_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_fall) begin
          if (!w_dat_s) begin
            w_state_next  = S_DATA;
            w_bitcnt_next = '0;
          end else begin
            w_ferr_next = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (r_fall) begin
          w_shreg_next = {w_dat_s, r_shreg[7:1]};
          if (r_bitcnt == 3'd7) begin
            w_state_next = S_PARITY;
          end else begin
            w_bitcnt_next = r_bitcnt + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (r_fall) begin
          w_par_next   = w_dat_s;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_fall) begin
          w_state_next = S_IDLE;
          if (!w_dat_s) begin
            w_ferr_next = 1'b1;
          end else if ((^{r_shreg, r_par}) != 1'b1) begin
            w_perr_next = 1'b1;
          end else begin
            w_push_next = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Mid-frame watchdog; any fall restarts it (default of 0 above).
    if (r_state != S_IDLE && !r_fall) begin
      if (r_tmo == TMO_LAST) begin
        w_state_next = S_IDLE;
        w_ferr_next  = 1'b1;
      end else begin
        w_tmo_next = r_tmo + TW'(1);
      end
    end
  end

  // ---------------- scancode FIFO (first-word fall-through)
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_write;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = ~w_empty & m_ready;
  // A full FIFO still accepts the byte when a pop frees a slot the same cycle.
  assign w_write = r_push & (~w_full | w_pop);

  // Storage write; r_shreg is untouched in IDLE, so it still holds the byte
  // during the push cycle that follows the stop bit.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= r_shreg;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign m_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign m_valid    = ~w_empty;
  assign fifo_count = r_count;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: drives PS/2 frames on the pins at a scaled-down bit
// rate, keeps expected scancodes in a queue and checks them as they are popped.
module tb_ps2_rx_fifo;
  localparam int FL    = 8;
  localparam int TMO   = 200;
  localparam int DEPTH = 16;
  localparam int H     = 20;   // half period of the PS/2 clock in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic [4:0] fifo_count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int n_cmp = 0;
  int n_mis = 0;
  int n_perr = 0;
  int n_ferr = 0;
  logic [7:0] sb[$];

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Count cycles in which each error strobe is high.
  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit; optional 3-cycle glitches in both clock halves.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_n(12); ps2_clk = 1'b0; wait_n(3); ps2_clk = 1'b1; wait_n(H - 15);
    end else wait_n(H);
    ps2_clk = 1'b0;
    if (glitch) begin
      wait_n(12); ps2_clk = 1'b1; wait_n(3); ps2_clk = 1'b0; wait_n(H - 15);
    end else wait_n(H);
    ps2_clk = 1'b1;
  endtask

  // Start, data LSB first, odd parity (optionally inverted); no stop bit.
  task automatic send_body(input logic [7:0] d, input logic bad_par, input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch);
    ps2_bit((~^d) ^ bad_par, glitch);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input bit glitch,
                            input bit expect_ok);
    if (expect_ok) sb.push_back(d);
    send_body(d, bad_par, glitch);
    ps2_bit(1'b1, glitch);
    wait_n(H);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    wait_n(5);
    n_cmp++;
    if ({m_valid, fifo_count, parity_err, frame_err, overflow, m_data} !== 17'h0) begin
      n_mis++;
      $display("FAIL reset_outputs: got valid=%b cnt=%0d perr=%b ferr=%b ovf=%b data=%h, required all 0",
               m_valid, fifo_count, parity_err, frame_err, overflow, m_data);
    end
    rst = 1'b1;
    wait_n(20);
    n_cmp++;
    if (n_perr != 0 || n_ferr != 0) begin
      n_mis++;
      $display("FAIL reset_release_err: got perr=%0d ferr=%0d, required 0/0", n_perr, n_ferr);
    end
  endtask

  task automatic test_latency;
    logic [7:0] exp;
    sb.push_back(8'h1C);
    send_body(8'h1C, 1'b0, 1'b0);
    ps2_data = 1'b1;
    wait_n(H);
    ps2_clk = 1'b0;
    wait_n(11);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_mis++; $display("FAIL lat_early: m_valid=%b required 0", m_valid);
    end
    wait_n(1);
    n_cmp++;
    if (m_valid !== 1'b1) begin
      n_mis++; $display("FAIL lat_valid: m_valid=%b required 1", m_valid);
    end
    exp = sb.pop_front();
    n_cmp++;
    if (m_data !== exp) begin
      n_mis++; $display("FAIL lat_data: m_data=%h required %h", m_data, exp);
    end
    m_ready = 1'b1; wait_n(1); m_ready = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_mis++; $display("FAIL lat_pop: m_valid=%b cnt=%0d required 0/0", m_valid, fifo_count);
    end
    wait_n(H - 13);
    ps2_clk = 1'b1;
    wait_n(H);
  endtask

  task automatic test_parity;
    int p0, f0;
    logic [7:0] exp;
    p0 = n_perr; f0 = n_ferr;
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (n_perr - p0 != 1 || n_ferr != f0 || fifo_count !== 5'd0) begin
      n_mis++;
      $display("FAIL parity_err: perr_cycles=%0d ferr_cycles=%0d cnt=%0d required 1/0/0",
               n_perr - p0, n_ferr - f0, fifo_count);
    end
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    exp = sb.pop_front();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== exp) begin
      n_mis++; $display("FAIL parity_next: valid=%b data=%h required 1/%h", m_valid, m_data, exp);
    end
    m_ready = 1'b1; wait_n(1); m_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int p0, f0;
    logic [7:0] exp;
    p0 = n_perr; f0 = n_ferr;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(8'h5A >> i), 1'b0);
    wait_n(2 * TMO);
    n_cmp++;
    if (n_ferr - f0 != 1 || n_perr != p0 || fifo_count !== 5'd0) begin
      n_mis++;
      $display("FAIL timeout_err: ferr_cycles=%0d perr_cycles=%0d cnt=%0d required 1/0/0",
               n_ferr - f0, n_perr - p0, fifo_count);
    end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    exp = sb.pop_front();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== exp) begin
      n_mis++; $display("FAIL timeout_next: valid=%b data=%h required 1/%h", m_valid, m_data, exp);
    end
    m_ready = 1'b1; wait_n(1); m_ready = 1'b0;
  endtask

  task automatic test_glitch;
    int p0, f0;
    logic [7:0] exp;
    p0 = n_perr; f0 = n_ferr;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (n_perr != p0 || n_ferr != f0) begin
      n_mis++; $display("FAIL glitch_err: perr=%0d ferr=%0d required 0/0", n_perr - p0, n_ferr - f0);
    end
    exp = sb.pop_front();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== exp || fifo_count !== 5'd1) begin
      n_mis++;
      $display("FAIL glitch_data: valid=%b data=%h cnt=%0d required 1/%h/1", m_valid, m_data, fifo_count, exp);
    end
    m_ready = 1'b1; wait_n(1); m_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [7:0] exp;
    m_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b0, i <= DEPTH);
    n_cmp++;
    if (fifo_count !== 5'(DEPTH) || overflow !== 1'b1) begin
      n_mis++; $display("FAIL ovf_state: cnt=%0d ovf=%b required %0d/1", fifo_count, overflow, DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || sb.size() == 0) begin
        n_mis++; $display("FAIL ovf_drain_valid: m_valid=%b queued=%0d required 1", m_valid, sb.size());
      end else begin
        exp = sb.pop_front();
        if (m_data !== exp) begin
          n_mis++; $display("FAIL ovf_drain_data: m_data=%h required %h", m_data, exp);
        end
      end
      m_ready = 1'b1; wait_n(1); m_ready = 1'b0;
    end
    n_cmp++;
    if (m_valid !== 1'b0 || overflow !== 1'b1) begin
      n_mis++; $display("FAIL ovf_empty: valid=%b ovf=%b required 0/1", m_valid, overflow);
    end
  endtask

  task automatic test_reset_midframe;
    int p0, f0;
    logic [7:0] exp;
    send_frame(8'h33, 1'b0, 1'b0, 1'b1);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'(8'h77 >> i), 1'b0);
    p0 = n_perr; f0 = n_ferr;
    rst = 1'b0;
    wait_n(3);
    sb.delete();
    n_cmp++;
    if ({m_valid, fifo_count, overflow, m_data} !== 15'h0) begin
      n_mis++;
      $display("FAIL rstmid_outputs: valid=%b cnt=%0d ovf=%b data=%h required all 0",
               m_valid, fifo_count, overflow, m_data);
    end
    rst = 1'b1;
    wait_n(2 * TMO);
    n_cmp++;
    if (n_perr != p0 || n_ferr != f0) begin
      n_mis++; $display("FAIL rstmid_err: perr=%0d ferr=%0d required 0/0", n_perr - p0, n_ferr - f0);
    end
    send_frame(8'h44, 1'b0, 1'b0, 1'b1);
    exp = sb.pop_front();
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== exp || fifo_count !== 5'd1) begin
      n_mis++;
      $display("FAIL rstmid_next: valid=%b data=%h cnt=%0d required 1/%h/1", m_valid, m_data, fifo_count, exp);
    end
    m_ready = 1'b1; wait_n(1); m_ready = 1'b0;
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp;
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (fifo_count !== 5'(DEPTH) || overflow !== 1'b0) begin
      n_mis++; $display("FAIL fpp_full: cnt=%0d ovf=%b required %0d/0", fifo_count, overflow, DEPTH);
    end
    sb.push_back(8'h30);
    send_body(8'h30, 1'b0, 1'b0);
    ps2_data = 1'b1;
    wait_n(H);
    ps2_clk = 1'b0;
    wait_n(11);
    exp = sb.pop_front();
    n_cmp++;
    if (m_data !== exp) begin
      n_mis++; $display("FAIL fpp_head: m_data=%h required %h", m_data, exp);
    end
    m_ready = 1'b1; wait_n(1); m_ready = 1'b0;
    n_cmp++;
    if (fifo_count !== 5'(DEPTH) || overflow !== 1'b0) begin
      n_mis++; $display("FAIL fpp_same_cycle: cnt=%0d ovf=%b required %0d/0", fifo_count, overflow, DEPTH);
    end
    wait_n(H - 12);
    ps2_clk = 1'b1;
    wait_n(H);
    for (int k = 0; k < DEPTH; k++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || sb.size() == 0) begin
        n_mis++; $display("FAIL fpp_drain_valid: m_valid=%b queued=%0d required 1", m_valid, sb.size());
      end else begin
        exp = sb.pop_front();
        if (m_data !== exp) begin
          n_mis++; $display("FAIL fpp_drain_data: m_data=%h required %h", m_data, exp);
        end
      end
      m_ready = 1'b1; wait_n(1); m_ready = 1'b0;
    end
    n_cmp++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_mis++; $display("FAIL fpp_empty: valid=%b cnt=%0d required 0/0", m_valid, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_parity();
    test_timeout();
    test_glitch();
    test_overflow();
    test_reset_midframe();
    test_full_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
